// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch-side constants and types
// Purpose: constants and the queue entry type shared by the prefetch buffer and its FIFO.
// Ports: none (package).
package fetch_pkg;
  localparam int XLEN = 32;
  localparam int PC_STEP = 4;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;  // addi x0,x0,0

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch queue storage with push/pop/flush
// Purpose: DEPTH-entry circular queue; flush empties it in one cycle.
// Ports: clk, reset (sync, active-high), flush, push, pop, wdata in;
//        rdata (head entry, combinational), count (entries held) out.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  assign rdata = mem[rd_ptr];

  // Storage carries no reset; count alone decides which entries are live.
  // A push into a full queue lands on rd_ptr, which is safe because the
  // caller only allows that together with a pop of the same entry.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/instr_prefetch_buffer.sv
// rtl/instr_prefetch_buffer.sv - sequential instruction prefetch queue for the IF stage
// Purpose: drives sequential PCs to a combinational instruction memory, queues
//          {pc, instr} pairs and presents the head to the core with valid/ready;
//          any redirect flushes the queue and restarts fetch at redirect_pc.
// Ports: clk, reset (sync, active-high); imem_addr out / imem_data in;
//        fetch_en, redirect_valid, redirect_pc, instr_ready in;
//        instr_valid, instr, instr_pc, occupancy out.
module instr_prefetch_buffer #(
  parameter int              DEPTH    = 4,
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [XLEN-1:0]        imem_addr,
  input  logic [XLEN-1:0]        imem_data,
  input  logic                   fetch_en,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  input  logic                   instr_ready,
  output logic                   instr_valid,
  output logic [XLEN-1:0]        instr,
  output logic [XLEN-1:0]        instr_pc,
  output logic [$clog2(DEPTH):0] occupancy
);
  import fetch_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0]   fetch_pc;
  logic [2*XLEN-1:0] head;
  logic [CW-1:0]     count;
  logic              full;
  logic              push;
  logic              pop;

  assign instr_valid = (count != '0);
  assign full        = (count == CW'(DEPTH));

  // A redirect suppresses both sides: the queue content is stale anyway.
  assign pop  = instr_valid & instr_ready & ~redirect_valid;
  assign push = fetch_en & ~redirect_valid & (~full | pop);

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (2 * XLEN)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push  (push),
    .pop   (pop),
    .wdata ({fetch_pc, imem_data}),
    .rdata (head),
    .count (count)
  );

  // Address arithmetic wraps modulo 2^XLEN by construction.
  always_ff @(posedge clk) begin
    if (reset)               fetch_pc <= RESET_PC;
    else if (redirect_valid) fetch_pc <= redirect_pc;
    else if (push)           fetch_pc <= fetch_pc + XLEN'(PC_STEP);
  end

  assign imem_addr = fetch_pc;
  assign occupancy = count;
  assign instr     = instr_valid ? head[XLEN-1:0] : XLEN'(NOP_INSTR);
  assign instr_pc  = instr_valid ? head[2*XLEN-1:XLEN] : '0;
endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// tb/tb_instr_prefetch_buffer.sv - self-checking bench for instr_prefetch_buffer
module tb_instr_prefetch_buffer;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_ready;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [2:0]  occupancy;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        en;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [2:0]  e_occ;
    logic [31:0] e_addr;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] sb[$];

  instr_prefetch_buffer #(.DEPTH(4), .XLEN(32), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_ready    (instr_ready),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .occupancy      (occupancy)
  );

  function automatic logic [31:0] imem_f(input logic [31:0] a);
    return 32'h100 + (a >> 2);
  endfunction

  assign imem_data = imem_f(imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic sb_load(input logic [31:0] start);
    sb.delete();
    for (int i = 0; i < 16; i++) sb.push_back(start + 32'(4 * i));
  endtask

  // One clock: scoreboard bookkeeping on the inputs about to be sampled,
  // then advance to 1 time unit after the rising edge.
  task automatic tick();
    logic [31:0] e;
    if (reset) sb_load(32'h0);
    else if (redirect_valid) sb_load(redirect_pc);
    else if (instr_valid && instr_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_empty: got pc %h expected no output", instr_pc);
      end else begin
        e = sb.pop_front();
        chk("sb_pc", instr_pc, e);
        chk("sb_instr", instr, imem_f(e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic en, input logic rv, input logic [31:0] rpc, input logic rdy,
                     input logic ev, input logic [31:0] epc, input logic [2:0] eocc,
                     input logic [31:0] eaddr);
    vec_t v;
    v.en = en; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.e_valid = ev; v.e_pc = epc; v.e_occ = eocc; v.e_addr = eaddr;
    vecs.push_back(v);
  endtask

  initial begin
    vec_t v;
    // Rows: inputs for one cycle, then expected state after that edge.
    add(1, 0, 0,      1, 1, 32'h00, 3'd1, 32'h04);  // first word one cycle after reset
    add(1, 0, 0,      1, 1, 32'h04, 3'd1, 32'h08);
    add(1, 0, 0,      1, 1, 32'h08, 3'd1, 32'h0C);
    add(1, 0, 0,      0, 1, 32'h08, 3'd2, 32'h10);  // stall: fills up
    add(1, 0, 0,      0, 1, 32'h08, 3'd3, 32'h14);
    add(1, 0, 0,      0, 1, 32'h08, 3'd4, 32'h18);
    add(1, 0, 0,      0, 1, 32'h08, 3'd4, 32'h18);  // full: addr frozen
    add(1, 0, 0,      0, 1, 32'h08, 3'd4, 32'h18);
    add(1, 0, 0,      1, 1, 32'h0C, 3'd4, 32'h1C);  // full + pop: push too
    add(1, 0, 0,      1, 1, 32'h10, 3'd4, 32'h20);
    add(0, 0, 0,      1, 1, 32'h14, 3'd3, 32'h20);  // drain one with fetch off
    add(1, 1, 32'h40, 1, 0, 32'h00, 3'd0, 32'h40);  // redirect with 3 queued
    add(1, 0, 0,      1, 1, 32'h40, 3'd1, 32'h44);
    add(1, 1, 32'h80, 1, 0, 32'h00, 3'd0, 32'h80);  // back-to-back redirects
    add(1, 1, 32'hC0, 1, 0, 32'h00, 3'd0, 32'hC0);
    add(1, 0, 0,      1, 1, 32'hC0, 3'd1, 32'hC4);
    add(0, 0, 0,      1, 0, 32'h00, 3'd0, 32'hC4);  // fetch off: pc holds
    add(0, 1, 32'h100,0, 0, 32'h00, 3'd0, 32'h100); // redirect while fetch off
    add(0, 0, 0,      0, 0, 32'h00, 3'd0, 32'h100);

    reset = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    tick(); tick();
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, NOP);
    chk("rst_pc", instr_pc, 32'h0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);

    reset = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      fetch_en = v.en; redirect_valid = v.rv; redirect_pc = v.rpc; instr_ready = v.rdy;
      tick();
      chk($sformatf("r%0d_valid", i), 32'(instr_valid), 32'(v.e_valid));
      chk($sformatf("r%0d_pc", i), instr_pc, v.e_pc);
      chk($sformatf("r%0d_instr", i), instr, v.e_valid ? imem_f(v.e_pc) : NOP);
      chk($sformatf("r%0d_occ", i), 32'(occupancy), 32'(v.e_occ));
      chk($sformatf("r%0d_addr", i), imem_addr, v.e_addr);
    end

    // Reset beats a simultaneous redirect and discards queued entries.
    redirect_valid = 1'b0; fetch_en = 1'b1; instr_ready = 1'b0;
    tick(); tick(); tick();
    chk("pre_rst_occ", 32'(occupancy), 32'd3);
    reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    chk("rst_redir_occ", 32'(occupancy), 32'd0);
    chk("rst_redir_addr", imem_addr, 32'h0);
    chk("rst_redir_valid", 32'(instr_valid), 32'd0);

    // PC wrap at the top of the address space.
    reset = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; instr_ready = 1'b1;
    tick();
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    redirect_valid = 1'b0;
    tick();
    chk("wrap_pc0", instr_pc, 32'hFFFF_FFFC);
    chk("wrap_addr1", imem_addr, 32'h0);
    tick();
    chk("wrap_pc1", instr_pc, 32'h0);
    chk("wrap_instr1", instr, 32'h100);
    tick();
    chk("wrap_pc2", instr_pc, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
